// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: fixed-latency mult/div into pending
// registers, single-cycle mthi/mtlo, and the architectural HI/LO pair.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        En,
    input  logic [2:0]  MDUCtrl,
    input  logic        Flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    logic [CW-1:0] count;
    logic [31:0]   ph;
    logic [31:0]   pl;
    logic          divZero;
    logic          go;

    logic [63:0]   prodS;
    logic [63:0]   prodU;
    logic [31:0]   aMag;
    logic [31:0]   bMag;
    logic [31:0]   qMag;
    logic [31:0]   rMag;
    logic [31:0]   quotS;
    logic [31:0]   remS;
    logic [31:0]   quotU;
    logic [31:0]   remU;

    assign Busy = (count != '0);
    assign go   = En & ~Flush & ~Busy & (MDUCtrl != OP_NONE);

    assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prodU = {32'd0, A} * {32'd0, B};

    // Signed division on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        aMag  = A[31] ? (~A + 32'd1) : A;
        bMag  = B[31] ? (~B + 32'd1) : B;
        qMag  = '0;
        rMag  = '0;
        quotU = '0;
        remU  = '0;
        if (B != '0) begin
            qMag  = aMag / bMag;
            rMag  = aMag % bMag;
            quotU = A / B;
            remU  = A % B;
        end
        quotS = (A[31] ^ B[31]) ? (~qMag + 32'd1) : qMag;
        remS  = A[31] ? (~rMag + 32'd1) : rMag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            ph      <= '0;
            pl      <= '0;
            divZero <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else if (Busy) begin
            count <= count - CW'(1);
            if (count == CW'(1) && !divZero) begin
                HI <= ph;
                LO <= pl;
            end
        end else if (go) begin
            case (MDUCtrl)
                OP_MULT: begin
                    {ph, pl} <= prodS;
                    divZero  <= 1'b0;
                    count    <= CW'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    {ph, pl} <= prodU;
                    divZero  <= 1'b0;
                    count    <= CW'(MULT_CYCLES);
                end
                OP_DIV: begin
                    pl      <= quotS;
                    ph      <= remS;
                    divZero <= (B == '0);
                    count   <= CW'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    pl      <= quotU;
                    ph      <= remU;
                    divZero <= (B == '0);
                    count   <= CW'(DIV_CYCLES);
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed cases plus random ops against an
// arithmetic reference model of HI/LO and Busy timing.
module tb_mdu_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        En;
    logic [2:0]  MDUCtrl;
    logic        Flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          checksTotal = 0;
    int          checksPassed = 0;
    bit          inReset = 1'b1;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    int          busyStart = 0;
    int          lastBusyCyc = -1;

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .En      (En),
        .MDUCtrl (MDUCtrl),
        .Flush   (Flush),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle of inputs at a negedge; the model decides acceptance for the next edge.
    task automatic applyStimulus(input logic en, input logic [2:0] op, input logic flush,
                                 input logic [31:0] a, input logic [31:0] b);
        int          c;
        longint      sa, sb;
        logic [63:0] p;
        exp_t        e;
        En = en; MDUCtrl = op; Flush = flush; A = a; B = b;
        c = cyc + 1;
        if (en && !flush && (c - 1 > lastBusyCyc) && op >= 3'd1 && op <= 3'd6) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                3'd1: begin p = 64'(sa * sb); modelHi = p[63:32]; modelLo = p[31:0]; end
                3'd2: begin p = {32'd0, a} * {32'd0, b}; modelHi = p[63:32]; modelLo = p[31:0]; end
                3'd3: if (b != 0) begin modelLo = 32'(sa / sb); modelHi = 32'(sa % sb); end
                3'd4: if (b != 0) begin modelLo = a / b; modelHi = a % b; end
                3'd5: modelHi = a;
                default: modelLo = a;
            endcase
            if (op <= 3'd4) begin
                busyStart   = c;
                lastBusyCyc = c + ((op <= 3'd2) ? MULT_N : DIV_N) - 1;
                e.due = lastBusyCyc + 1;
            end else begin
                e.due = c;
            end
            e.hi = modelHi;
            e.lo = modelLo;
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        En = 1'b0; MDUCtrl = 3'd0; Flush = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int budget = 60;
        idle(0);
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sbq.size() > 0) begin
            checksTotal++;
            $display("[TB] FAIL drain_timeout: %0d entries left, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: Busy every cycle, HI/LO whenever a scoreboard entry comes due.
    always @(negedge clk) begin
        if (!inReset) begin
            exp_t e;
            checkOutput("busy", {31'd0, Busy}, {31'd0, (cyc >= busyStart && cyc <= lastBusyCyc)});
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                checkOutput("hi", HI, e.hi);
                checkOutput("lo", LO, e.lo);
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        reset_n = 1'b1; En = 1'b0; MDUCtrl = 3'd0; Flush = 1'b0; A = '0; B = '0;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        inReset = 1'b0;

        applyStimulus(1, 3'd5, 0, 32'h0000AAAA, 32'd0);
        applyStimulus(1, 3'd6, 0, 32'h00005555, 32'd0);
        idle(1);

        applyStimulus(1, 3'd1, 0, 32'hFFFFFFFE, 32'd3);
        idle(1);
        #2 inReset = 1'b1;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_hi", HI, 32'd0);
        checkOutput("midreset_lo", LO, 32'd0);
        checkOutput("midreset_busy", {31'd0, Busy}, 32'd0);
        sbq.delete();
        modelHi = '0; modelLo = '0; lastBusyCyc = -1;
        #1 reset_n = 1'b1;
        @(negedge clk);
        inReset = 1'b0;
        idle(8);
        checkOutput("postreset_hi", HI, 32'd0);
        checkOutput("postreset_lo", LO, 32'd0);

        applyStimulus(1, 3'd1, 0, 32'hFFFFFFFE, 32'd3); drain();
        checkOutput("mult_hi", HI, 32'hFFFFFFFF);
        checkOutput("mult_lo", LO, 32'hFFFFFFFA);
        applyStimulus(1, 3'd2, 0, 32'hFFFFFFFE, 32'd3); drain();
        checkOutput("multu_hi", HI, 32'h00000002);
        applyStimulus(1, 3'd3, 0, 32'hFFFFFFF9, 32'd2); drain();
        checkOutput("div_lo", LO, 32'hFFFFFFFD);
        checkOutput("div_hi", HI, 32'hFFFFFFFF);
        applyStimulus(1, 3'd4, 0, 32'd7, 32'd0); drain();
        checkOutput("divz_hi", HI, 32'hFFFFFFFF);
        applyStimulus(1, 3'd3, 0, 32'h80000000, 32'hFFFFFFFF); drain();
        checkOutput("intmin_lo", LO, 32'h80000000);
        checkOutput("intmin_hi", HI, 32'h00000000);

        applyStimulus(1, 3'd6, 0, 32'h00001234, 32'd0); drain();
        checkOutput("mtlo_lo", LO, 32'h00001234);
        applyStimulus(1, 3'd5, 1, 32'hDEADBEEF, 32'd0); idle(1);
        checkOutput("flush_hi", HI, modelHi);

        applyStimulus(1, 3'd1, 0, 32'd1000, 32'd77);
        repeat (4) applyStimulus(0, 3'd0, 1, 32'd0, 32'd0);
        drain();
        checkOutput("flushbusy_lo", LO, 32'd77000);

        applyStimulus(1, 3'd2, 0, 32'h12345678, 32'h9ABCDEF0);
        repeat (8) applyStimulus(1, 3'd5, 0, 32'hCAFEF00D, 32'd0);
        drain();
        checkOutput("b2b_hi", HI, 32'hCAFEF00D);
        checkOutput("b2b_lo", LO, 32'h242D2080);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
            applyStimulus($urandom_range(0, 9) != 0, rop, $urandom_range(0, 5) == 0, ra, rb);
            idle($urandom_range(0, 12));
        end
        drain();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
